// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N-channel stream multiplexer.
package stream_mux_pkg;

    // Arbitration source for the unlocked grant
    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    // Packet lock state
    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    // Width of a channel index; never narrower than one bit
    function automatic int sel_width(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage : stream_mux_pkg

// File: rtl/stream_mux_n_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester above ptr_i,
// wrapping modulo NumCh, so the channel at ptr_i has the lowest priority.
module rr_arbiter_n
    import stream_mux_pkg::*;
#(
    parameter int NumCh    = 3,
    parameter int SelWidth = sel_width(NumCh)
) (
    input  logic [NumCh-1:0]    req_i,
    input  logic [SelWidth-1:0] ptr_i,
    output logic [NumCh-1:0]    gnt_o,
    output logic [SelWidth-1:0] idx_o
);

    // Search ptr+1, ptr+2, ... ptr (mod NumCh) and keep the first hit
    always_comb begin
        int  k;
        logic found;
        k     = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int i = 1; i <= NumCh; i++) begin
            k = (int'(ptr_i) + i) % NumCh;
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = SelWidth'(k);
            end
        end
    end

endmodule : rr_arbiter_n

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream multiplexer with a registered output stage
// and packet-level grant locking.
//
// state       | meaning
// ST_UNLOCKED | grant follows select_i (MODE_SEL) or the round-robin arbiter
// ST_LOCKED   | grant pinned to lock_ch_q until its last beat is accepted
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int    DWidth = 32,
    parameter int    NumCh  = 3,
    parameter mode_e Mode   = MODE_SEL,
    localparam int   SelWidth = sel_width(NumCh)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumCh-1:0]        valid_i,
    input  logic [NumCh*DWidth-1:0] data_i,
    input  logic [NumCh-1:0]        last_i,
    output logic [NumCh-1:0]        ready_o,
    input  logic [SelWidth-1:0]     select_i,
    output logic                    valid_o,
    output logic [DWidth-1:0]       data_o,
    output logic                    last_o,
    output logic [SelWidth-1:0]     ch_o,
    input  logic                    ready_i,
    output logic                    sel_err_o
);

    lock_state_e         state_q;
    logic [SelWidth-1:0] lock_ch_q;
    logic                valid_q;
    logic [DWidth-1:0]   data_q;
    logic                last_q;
    logic [SelWidth-1:0] ch_q;
    logic                sel_err_q;

    logic                advance;
    logic [NumCh-1:0]    gnt_vec;
    logic [SelWidth-1:0] gnt_idx;
    logic                sel_oor;
    logic [DWidth-1:0]   sel_data;
    logic                sel_last;
    logic                accept;

    logic [NumCh-1:0]    arb_gnt;
    logic [SelWidth-1:0] arb_idx;

    // Output register can take a new beat when empty or being drained
    assign advance = !valid_q || ready_i;

    // Round-robin arbiter and its pointer only exist in MODE_RR; the pointer
    // moves only on a packet's last beat so fairness is per packet, not per beat
    if (Mode == MODE_RR) begin : g_rr
        logic [SelWidth-1:0] ptr_q;

        // Pointer starts at the top channel so channel 0 wins first
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                ptr_q <= SelWidth'(NumCh - 1);
            end else if (accept && sel_last) begin
                ptr_q <= gnt_idx;
            end
        end

        rr_arbiter_n #(
            .NumCh    (NumCh),
            .SelWidth (SelWidth)
        ) u_arb (
            .req_i (valid_i),
            .ptr_i (ptr_q),
            .gnt_o (arb_gnt),
            .idx_o (arb_idx)
        );
    end else begin : g_sel
        assign arb_gnt = '0;
        assign arb_idx = '0;
    end

    // Grant selection: lock overrides everything, then the mode's arbiter
    always_comb begin
        gnt_vec = '0;
        gnt_idx = '0;
        sel_oor = 1'b0;
        if (state_q == ST_LOCKED) begin
            gnt_vec[lock_ch_q] = 1'b1;
            gnt_idx            = lock_ch_q;
        end else if (Mode == MODE_RR) begin
            gnt_vec = arb_gnt;
            gnt_idx = arb_idx;
        end else if (int'(select_i) < NumCh) begin
            gnt_vec[select_i] = 1'b1;
            gnt_idx           = select_i;
        end else begin
            sel_oor = 1'b1;
        end
    end

    // Data/last of the granted channel; grant is one-hot or empty
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < NumCh; k++) begin
            if (gnt_vec[k]) begin
                sel_data = data_i[k*DWidth +: DWidth];
                sel_last = last_i[k];
            end
        end
    end

    assign accept  = advance && |(gnt_vec & valid_i);
    assign ready_o = gnt_vec & {NumCh{advance}};

    // Lock FSM, output beat register and sticky select error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_UNLOCKED;
            lock_ch_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            ch_q      <= '0;
            sel_err_q <= 1'b0;
        end else begin
            if (sel_oor) begin
                sel_err_q <= 1'b1;
            end
            if (accept) begin
                valid_q <= 1'b1;
                data_q  <= sel_data;
                last_q  <= sel_last;
                ch_q    <= gnt_idx;
                case (state_q)
                    ST_UNLOCKED: begin
                        if (!sel_last) begin
                            state_q   <= ST_LOCKED;
                            lock_ch_q <= gnt_idx;
                        end
                    end
                    ST_LOCKED: begin
                        if (sel_last) begin
                            state_q <= ST_UNLOCKED;
                        end
                    end
                    default: state_q <= ST_UNLOCKED;
                endcase
            end else if (advance) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign last_o    = last_q;
    assign ch_o      = ch_q;
    assign sel_err_o = sel_err_q;

endmodule : stream_mux_n

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: one MODE_SEL and one MODE_RR instance
// sharing clock and reset, each checked against hand-computed beats.
module tb_stream_mux_n;
    import stream_mux_pkg::*;

    localparam int DW = 8;
    localparam int NC = 3;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // MODE_SEL instance signals
    logic [NC-1:0]    s_valid_i = '0;
    logic [NC*DW-1:0] s_data_i  = '0;
    logic [NC-1:0]    s_last_i  = '0;
    logic [NC-1:0]    s_ready_o;
    logic [SW-1:0]    s_select_i = '0;
    logic             s_valid_o;
    logic [DW-1:0]    s_data_o;
    logic             s_last_o;
    logic [SW-1:0]    s_ch_o;
    logic             s_ready_i = 1'b1;
    logic             s_sel_err_o;

    // MODE_RR instance signals
    logic [NC-1:0]    r_valid_i = '0;
    logic [NC*DW-1:0] r_data_i  = '0;
    logic [NC-1:0]    r_last_i  = '0;
    logic [NC-1:0]    r_ready_o;
    logic [SW-1:0]    r_select_i = '0;
    logic             r_valid_o;
    logic [DW-1:0]    r_data_o;
    logic             r_last_o;
    logic [SW-1:0]    r_ch_o;
    logic             r_ready_i = 1'b1;
    logic             r_sel_err_o;

    stream_mux_n #(.DWidth(DW), .NumCh(NC), .Mode(MODE_SEL)) u_sel (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (s_valid_i),
        .data_i    (s_data_i),
        .last_i    (s_last_i),
        .ready_o   (s_ready_o),
        .select_i  (s_select_i),
        .valid_o   (s_valid_o),
        .data_o    (s_data_o),
        .last_o    (s_last_o),
        .ch_o      (s_ch_o),
        .ready_i   (s_ready_i),
        .sel_err_o (s_sel_err_o)
    );

    stream_mux_n #(.DWidth(DW), .NumCh(NC), .Mode(MODE_RR)) u_rr (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (r_valid_i),
        .data_i    (r_data_i),
        .last_i    (r_last_i),
        .ready_o   (r_ready_o),
        .select_i  (r_select_i),
        .valid_o   (r_valid_o),
        .data_o    (r_data_o),
        .last_o    (r_last_o),
        .ch_o      (r_ch_o),
        .ready_i   (r_ready_i),
        .sel_err_o (r_sel_err_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one beat on a SEL-instance channel
    task automatic s_put(input int ch, input logic [DW-1:0] d, input logic l);
        s_valid_i[ch]          = 1'b1;
        s_data_i[ch*DW +: DW]  = d;
        s_last_i[ch]           = l;
        #1;
    endtask

    task automatic s_beat(input string tag, input logic [DW-1:0] d, input logic l, input int ch);
        chk({tag, ".valid"}, 32'(s_valid_o), 32'd1);
        chk({tag, ".data"},  32'(s_data_o),  32'(d));
        chk({tag, ".last"},  32'(s_last_o),  32'(l));
        chk({tag, ".ch"},    32'(s_ch_o),    32'(ch));
    endtask

    int rr_seq_a [6] = '{0, 1, 2, 0, 1, 2};
    int rr_seq_b [4] = '{0, 2, 0, 2};

    initial begin
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst.valid",   32'(s_valid_o),   32'd0);
        chk("rst.last",    32'(s_last_o),    32'd0);
        chk("rst.data",    32'(s_data_o),    32'd0);
        chk("rst.ch",      32'(s_ch_o),      32'd0);
        chk("rst.sel_err", 32'(s_sel_err_o), 32'd0);
        chk("rst.rr_valid", 32'(r_valid_o),  32'd0);

        // --- MODE_SEL: 3-beat packet on ch1, select switches after A1 ---
        s_select_i = 2'd1;
        s_put(0, 8'hB1, 1'b1);
        s_put(1, 8'hA1, 1'b0);
        chk("pkt.rdy1", 32'(s_ready_o), 32'b010);
        tick();
        s_beat("pkt.A1", 8'hA1, 1'b0, 1);
        s_select_i = 2'd0;
        s_put(1, 8'hA2, 1'b0);
        chk("lock.rdy2", 32'(s_ready_o), 32'b010);
        tick();
        s_beat("lock.A2", 8'hA2, 1'b0, 1);
        s_put(1, 8'hA3, 1'b1);
        chk("lock.rdy3", 32'(s_ready_o), 32'b010);
        tick();
        s_beat("lock.A3", 8'hA3, 1'b1, 1);
        s_valid_i[1] = 1'b0;
        #1;
        chk("unlock.rdy", 32'(s_ready_o), 32'b001);
        tick();
        s_beat("unlock.B1", 8'hB1, 1'b1, 0);

        // --- backpressure ---
        s_put(0, 8'hB2, 1'b0);
        tick();
        s_beat("bp.B2", 8'hB2, 1'b0, 0);
        s_ready_i = 1'b0;
        s_put(0, 8'hB3, 1'b1);
        chk("bp.rdy0", 32'(s_ready_o), 32'b000);
        tick();
        s_beat("bp.hold1", 8'hB2, 1'b0, 0);
        chk("bp.rdy1", 32'(s_ready_o), 32'b000);
        tick();
        s_beat("bp.hold2", 8'hB2, 1'b0, 0);
        s_ready_i = 1'b1;
        #1;
        chk("bp.rdy_rel", 32'(s_ready_o), 32'b001);
        tick();
        s_beat("bp.B3", 8'hB3, 1'b1, 0);
        s_valid_i = '0;
        tick();
        chk("bp.drain", 32'(s_valid_o), 32'd0);

        // --- out-of-range select ---
        s_put(0, 8'hB4, 1'b1);
        s_select_i = 2'd3;
        #1;
        chk("oor.rdy", 32'(s_ready_o), 32'b000);
        tick();
        chk("oor.valid", 32'(s_valid_o),   32'd0);
        chk("oor.err",   32'(s_sel_err_o), 32'd1);
        s_select_i = 2'd0;
        #1;
        chk("oor.rdy_ok", 32'(s_ready_o), 32'b001);
        tick();
        s_beat("oor.B4", 8'hB4, 1'b1, 0);
        chk("oor.sticky", 32'(s_sel_err_o), 32'd1);
        s_valid_i = '0;

        // --- reset in the middle of a ch2 packet ---
        s_select_i = 2'd2;
        s_put(2, 8'hC1, 1'b0);
        tick();
        s_beat("mid.C1", 8'hC1, 1'b0, 2);
        s_put(2, 8'hC2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid.valid", 32'(s_valid_o),   32'd0);
        chk("mid.err",   32'(s_sel_err_o), 32'd0);
        s_select_i = 2'd0;
        s_put(0, 8'hD1, 1'b1);
        chk("mid.rdy", 32'(s_ready_o), 32'b001);
        tick();
        s_beat("mid.D1", 8'hD1, 1'b1, 0);
        s_valid_i = '0;
        tick();

        // --- MODE_RR: all channels sending single-beat packets ---
        r_data_i  = {8'hC2, 8'hC1, 8'hC0};
        r_last_i  = 3'b111;
        r_valid_i = 3'b111;
        #1;
        chk("rr.rdy0", 32'(r_ready_o), 32'b001);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rr.all%0d.ch", i),   32'(r_ch_o),   32'(rr_seq_a[i]));
            chk($sformatf("rr.all%0d.data", i), 32'(r_data_o), 32'(8'hC0 + rr_seq_a[i]));
        end
        r_valid_i = 3'b101;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr.skip%0d.ch", i), 32'(r_ch_o), 32'(rr_seq_b[i]));
        end

        // Move the pointer to ch0, then reset: ch0 must still win first
        r_valid_i = 3'b001;
        tick();
        chk("rr.ptr0.ch", 32'(r_ch_o), 32'd0);
        r_valid_i = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr.rst.valid", 32'(r_valid_o), 32'd0);
        r_valid_i = 3'b111;
        #1;
        chk("rr.rst.rdy", 32'(r_ready_o), 32'b001);
        tick();
        chk("rr.rst.ch", 32'(r_ch_o), 32'd0);
        r_valid_i = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stream_mux_n

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- N-channel valid/ready stream multiplexer with a registered output stage. It is the parametrised successor of the datapath 3:1 select mux.
- Adds the following over the select mux: a channel count parameter, packet-level grant locking on `last`, an optional round-robin arbitration mode, backpressure, and out-of-range select detection.
- Sits between multiple producers (for example PE result streams) and a single consumer (for example a writeback buffer).

Parameters:
- DWidth, 32, data width per channel.
- NumCh, 3, number of input channels (≥2).
- Mode, MODE_SEL, arbitration mode: MODE_SEL (external select_i) or MODE_RR (round-robin).
- SelWidth, $clog2(NumCh), localparam, width of select/channel id.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  NumCh  per-channel valid.
- data_i  in  NumCh*DWidth  per-channel data, channel k at bits [k*DWidth +: DWidth].
- last_i  in  NumCh  per-channel end-of-packet marker.
- ready_o  out  NumCh  per-channel ready.
- select_i  in  SelWidth  channel select, used in MODE_SEL only (ignored in MODE_RR).
- valid_o  out  1  output valid.
- data_o  out  DWidth  output data.
- last_o  out  1  output end-of-packet.
- ch_o  out  SelWidth  source channel of the current output beat.
- ready_i  in  1  consumer ready.
- sel_err_o  out  1  sticky out-of-range select flag.

Behaviour:
- Reset (rst_i=1 at a clock edge) clears:
  - valid_o, last_o, sel_err_o, ch_o, data_o to 0.
  - Lock state to UNLOCKED.
  - Round-robin pointer to NumCh-1, so channel 0 has first priority.
- Reset during a packet drops the lock and any buffered beat with no flush.
- Output register:
  - advance = !valid_o || ready_i.
  - A beat is accepted from channel g when grant[g] && valid_i[g] && advance.
  - On accept: data_o, last_o, and ch_o take channel g's values and ch_o=g; valid_o=1.
  - If advance is true with no accept, valid_o=0.
  - Latency is 1 cycle input to output.
  - Full throughput: one beat per cycle when ready_i is held at 1.
- ready_o[k] = grant[k] && advance. At most one ready_o bit is high per cycle. ready_o is combinational from the grant, valid_o and ready_i.
- Producers keep valid_i and data_i stable until ready_o is seen, the same rule as valid_o/data_o toward the consumer.
- Output stability: while valid_o && !ready_i, all outputs hold.
- State machine:
  - UNLOCKED: the grant comes from the arbiter in the same cycle.
    - If the beat accepted has last_i=0, go to LOCKED(g).
    - If last_i=1, stay UNLOCKED.
  - LOCKED(g): grant is fixed to g regardless of select_i or other valids. Leave for UNLOCKED when a beat from g with last_i=1 is accepted.
- MODE_SEL grant, when UNLOCKED:
  - grant = onehot(select_i) if select_i < NumCh.
  - If select_i ≥ NumCh: no grant, no ready_o, and sel_err_o set sticky until reset.
  - Only an out-of-range select while UNLOCKED sets sel_err_o. While LOCKED, select_i is ignored.
- MODE_RR grant, when UNLOCKED:
  - Grant the first k with valid_i[k], searching from ptr+1 upward modulo NumCh.
  - ptr updates to g only on an accepted beat that has last_i=1 (packet-granular fairness).
  - No valid input: no grant, ptr unchanged.
- Single-beat packets (last_i=1 on the first beat) never enter LOCKED.
- A channel dropping valid_i mid-packet while LOCKED stalls the output (valid_o goes 0 after the buffered beat drains). The lock is retained.

Decomposition:
- Package stream_mux_pkg: mode enum (MODE_SEL=0, MODE_RR=1) and a function computing SelWidth.
- Sub-module rr_arbiter_n:
  - Inputs: request vector and pointer.
  - Output: one-hot grant plus binary index.
  - Purely combinational, NumCh parameter.
  - Instantiated only in MODE_RR, via a generate block.

Test Plan:
- MODE_SEL, NumCh=3, select_i=1, ch1 sends 3-beat packet A1,A2,A3 (last on A3), ready_i=1:
  - data_o = A1,A2,A3 on cycles T+1..T+3.
  - ch_o=1 and last_o=1 on the A3 cycle.
  - ready_o=3'b010 throughout.
- MODE_SEL lock: select_i changes 1→0 after A1 is accepted.
  - A2 and A3 still come from ch1.
  - The first ch0 beat appears only after A3 is accepted.
- Backpressure: ready_i=0 for 2 cycles with valid_o=1.
  - data_o, last_o and ch_o are held.
  - ready_o=0.
  - No beat is lost or duplicated after ready_i=1.
- MODE_SEL, select_i=3 with NumCh=3:
  - ready_o=0 and valid_o stays 0.
  - sel_err_o=1 next cycle and remains 1 after select_i=0, until rst_i.
- MODE_RR, all three channels continuously send single-beat packets:
  - Output ch_o sequence is 0,1,2,0,1,2.
  - With ch1 idle, the sequence is 0,2,0,2.
- Reset mid-packet (LOCKED on ch2, valid_o=1):
  - Next cycle valid_o=0 and sel_err_o=0.
  - Lock is released, so a new select_i=0 packet is accepted immediately.
  - RR pointer is back to NumCh-1.
